data_memory_ctrl: RTL and testbench

Multi-cycle data-memory responder for the MEM stage of the pipelined ARM core. It accepts the load/store request the MEM stage issues (effective address from the ALU, store data from Val_Rm) and serves it from an internal word array after a fixed number of wait states. While a request is outstanding it raises `freeze`, which stalls every pipeline register up to and including the MEM stage register. On completion it returns `read_data` together with a one-cycle `ready` pulse.

---
 rtl/data_memory_ctrl.sv | 144 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_memory_ctrl: multi-cycle MEM-stage data memory with freeze / ready   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module data_memory_ctrl #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 3,
   parameter int BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        freeze
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_rd_q, is_rd_d;
   logic               is_wr_q, is_wr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        read_data_q, read_data_d;
   logic               ready_q, ready_d;

   logic [31:0]        mem_q [DEPTH];
   logic               mem_we;
   logic               mem_re;
   logic [IDX_W-1:0]   mem_idx;
   logic [31:0]        mem_wdata;
   logic [IDX_W-1:0]   req_idx;

   // Out-of-range addresses wrap because only the low index bits are kept.
   assign req_idx = IDX_W'((address - 32'(BASE_ADDR)) >> 2);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_rd_d     = is_rd_q;
      is_wr_d     = is_wr_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;
      ready_d     = 1'b0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      mem_idx     = idx_q;
      mem_wdata   = wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (mem_read | mem_write) begin
               is_rd_d = mem_read;
               is_wr_d = mem_write;
               idx_d   = req_idx;
               wdata_d = write_data;
               cnt_d   = C_CNT_LOAD;
               if (WAIT_CYCLES == 1) begin
                  // Single wait state: the access happens on the accepting edge.
                  state_d   = ST_DONE;
                  ready_d   = 1'b1;
                  mem_we    = mem_write;
                  mem_re    = mem_read;
                  mem_idx   = req_idx;
                  mem_wdata = write_data;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == C_CNT_LAST) begin
               state_d = ST_DONE;
               ready_d = 1'b1;
               mem_we  = is_wr_q;
               mem_re  = is_rd_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A combined read+write returns the word as it was before the store.
      if (mem_re) begin
         read_data_d = mem_q[mem_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         is_rd_q     <= 1'b0;
         is_wr_q     <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_rd_q     <= is_rd_d;
         is_wr_q     <= is_wr_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         read_data_q <= read_data_d;
         ready_q     <= ready_d;
      end
   end

   // Array contents survive reset; a reset during WAIT suppresses the write.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[mem_idx] <= mem_wdata;
      end
   end

   assign read_data = read_data_q;
   assign ready     = ready_q;
   assign freeze    = (mem_read | mem_write) & ~ready_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_memory_ctrl: scoreboard bench for data_memory_ctrl                |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_data_memory_ctrl;

   localparam int PERIOD = 10;
   localparam int WAITC  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [31:0] address, write_data, read_data;
   logic        ready, freeze;

   logic        r1, w1;
   logic [31:0] a1, d1, rd1;
   logic        rdy1, frz1;

   data_memory_ctrl #(.DEPTH(64), .WAIT_CYCLES(WAITC), .BASE_ADDR(1024)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .address(address), .write_data(write_data), .read_data(read_data),
      .ready(ready), .freeze(freeze)
   );

   data_memory_ctrl #(.DEPTH(64), .WAIT_CYCLES(1), .BASE_ADDR(1024)) dut1 (
      .clk(clk), .rst(rst), .mem_read(r1), .mem_write(w1),
      .address(a1), .write_data(d1), .read_data(rd1),
      .ready(rdy1), .freeze(frz1)
   );

   always #(PERIOD/2) clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model[64];
   logic [31:0] last_rd = 32'd0;
   int          fcnt = 0;
   bit          prev_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Freeze duration per access and the freeze equation, sampled mid-cycle.
   initial forever begin
      @(negedge clk);
      #1;
      if (rst) begin
         fcnt = 0;
      end else begin
         if (freeze) fcnt++;
         check("freeze_eq", 32'(freeze), 32'((mem_read | mem_write) & ~ready));
      end
   end

   // Scoreboard monitor: every ready pulse pops one expected read_data.
   initial forever begin
      @(posedge clk);
      #1;
      if (rst) begin
         prev_rdy = 1'b0;
      end else begin
         if (ready) begin
            check("ready_single_cycle", 32'(prev_rdy), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_ready", 32'd1, 32'd0);
            end else begin
               check("read_data", read_data, exp_q.pop_front());
            end
            check("freeze_cycles", 32'(fcnt), 32'(WAITC));
            fcnt = 0;
         end
         prev_rdy = ready;
      end
   end

   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output time t_rdy);
      logic [31:0] off;
      int          idx;
      bit          seen;
      seen = 1'b0;
      @(negedge clk);
      mem_read = rd; mem_write = wr; address = a; write_data = d;
      off = a - 32'd1024;
      idx = int'(off[7:2]);
      if (rd) last_rd = model[idx];
      if (wr) model[idx] = d;
      exp_q.push_back(last_rd);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (ready) seen = 1'b1;
      end
      t_rdy = $time;
      if (!seen) begin
         check("ready_timeout", 32'd0, 32'd1);
         exp_q.delete();
      end
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic w1_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd);
      @(negedge clk);
      r1 = rd; w1 = wr; a1 = a; d1 = d;
      #1;
      check("w1_freeze_accept", 32'(frz1), 32'd1);
      @(posedge clk);
      #1;
      check("w1_ready", 32'(rdy1), 32'd1);
      check("w1_freeze_done", 32'(frz1), 32'd0);
      check("w1_read_data", rd1, exp_rd);
      @(negedge clk);
      r1 = 1'b0; w1 = 1'b0;
      @(posedge clk);
      #1;
      check("w1_ready_single", 32'(rdy1), 32'd0);
   endtask

   initial begin
      #(PERIOD * 20000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      time t1, t2, tx;
      int  op;
      rst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
      r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_read_data", read_data, 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_freeze_idle", 32'(freeze), 32'd0);
      mem_read = 1'b1;
      #1;
      check("rst_freeze_req", 32'(freeze), 32'd1);
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 64; i++) access(1'b0, 1'b1, 32'(1024 + 4 * i), $urandom, tx);

      access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, tx);
      access(1'b1, 1'b0, 32'd1028, 32'd0, tx);
      check("load_deadbeef", read_data, 32'hDEADBEEF);

      access(1'b0, 1'b1, 32'd1280, 32'h11111111, tx);
      access(1'b1, 1'b0, 32'd1024, 32'd0, tx);
      check("wrap_load", read_data, 32'h11111111);

      access(1'b0, 1'b1, 32'd1032, 32'hA5A5A5A5, tx);
      access(1'b1, 1'b1, 32'd1032, 32'h5A5A5A5A, tx);
      check("rw_prewrite", read_data, 32'hA5A5A5A5);
      access(1'b1, 1'b0, 32'd1032, 32'd0, tx);
      check("rw_after", read_data, 32'h5A5A5A5A);

      // Abort a store with reset in its second cycle.
      @(negedge clk);
      mem_write = 1'b1; address = 32'd1040; write_data = 32'h12345678;
      @(negedge clk);
      rst = 1'b1; mem_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_rd = 32'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("abort_no_ready", 32'(ready), 32'd0);
      end
      check("abort_read_data", read_data, 32'd0);
      access(1'b1, 1'b0, 32'd1040, 32'd0, tx);

      access(1'b1, 1'b0, 32'd1024, 32'd0, t1);
      access(1'b1, 1'b0, 32'd1028, 32'd0, t2);
      check("b2b_spacing", 32'(t2 - t1), 32'(4 * PERIOD));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("idle_freeze", 32'(freeze), 32'd0);
         check("idle_ready", 32'(ready), 32'd0);
      end

      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(1, 3);
         access(op[0], op[1], 32'd1024 + $urandom_range(0, 1023), $urandom, tx);
      end

      w1_access(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 32'd0);
      w1_access(1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
